// File: rtl/countdown_display_ctrl.sv
// countdown_display_ctrl: BCD countdown timer driving one active-low 7-segment
// display per digit, with defuse/clear, an internal half-second time base and a
// blinking dash pattern on expiry.
// Optional feature: define COUNTDOWN_PAUSE_EN to get the pause port and the
// PAUSED state. Without it the state encoding is the same, but PAUSED is never
// entered.

// Segment decoder for one digit. It shows dash/blank while in BOOM and the
// decimal value otherwise. The decimal point is always off.
module countdown_seg_dec (
  input  logic [3:0] bcd,
  input  logic       boom,
  input  logic       blank,
  output logic [7:0] seg
);
  // value -> active-low {dp,g,f,e,d,c,b,a}
  always_comb begin
    seg = 8'hFF;
    if (boom) begin
      seg = blank ? 8'hFF : 8'hBF;
    end else begin
      case (bcd)
        4'd0:    seg = 8'hC0;
        4'd1:    seg = 8'hF9;
        4'd2:    seg = 8'hA4;
        4'd3:    seg = 8'hB0;
        4'd4:    seg = 8'h99;
        4'd5:    seg = 8'h92;
        4'd6:    seg = 8'h82;
        4'd7:    seg = 8'hF8;
        4'd8:    seg = 8'h80;
        4'd9:    seg = 8'h90;
        default: seg = 8'hFF;
      endcase
    end
  end
endmodule

module countdown_display_ctrl #(
  parameter int DIGITS      = 4,
  parameter int HALF_PERIOD = 25_000_000
) (
  input  logic                  clk,
  input  logic                  async_nreset,
  input  logic                  start,
  input  logic                  defuse,
`ifdef COUNTDOWN_PAUSE_EN
  input  logic                  pause,
`endif
  input  logic                  clear,
  input  logic [4*DIGITS-1:0]   preset_bcd,
  output logic [8*DIGITS-1:0]   hex_out,
  output logic [2:0]            state,
  output logic                  exploded
);
  localparam int DW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PAUSED  = 3'd2,
    S_DEFUSED = 3'd3,
    S_BOOM    = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [DIGITS-1:0][3:0]    digits_q, digits_d;
  logic [DW-1:0]             div_q, div_d;
  logic                      phase_q, phase_d;
  logic                      blink_q, blink_d;   // 1 = blank half of the BOOM blink

  logic                      pause_w;
  logic                      run_div, half_tick, sec_tick;
  logic [DIGITS-1:0][3:0]    preset_clamped, digits_dec;

`ifdef COUNTDOWN_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  assign run_div   = (state_q == S_RUN) || (state_q == S_BOOM);
  assign half_tick = run_div && (div_q == DIV_LAST);
  assign sec_tick  = half_tick && phase_q;

  // Clamp each preset digit to 9
  always_comb begin
    preset_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      preset_clamped[i] = (preset_bcd[4*i +: 4] > 4'd9) ? 4'd9 : preset_bcd[4*i +: 4];
    end
  end

  // BCD decrement by one, rippling the borrow up from digit 0
  always_comb begin
    logic borrow;
    digits_dec = digits_q;
    borrow     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (digits_q[i] == 4'd0) begin
          digits_dec[i] = 4'd9;
        end else begin
          digits_dec[i] = digits_q[i] - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
  end

  // Next-state logic: time base, digit update and state transitions
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    div_d    = div_q;
    phase_d  = phase_q;
    blink_d  = blink_q;

    // The divider advances in every RUN/BOOM cycle. A pause or defuse on a tick
    // cycle still consumes that tick.
    if (run_div) begin
      if (half_tick) begin
        div_d   = '0;
        phase_d = ~phase_q;
      end else begin
        div_d = div_q + DW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          digits_d = preset_clamped;
          div_d    = '0;
          phase_d  = 1'b0;
          state_d  = (preset_clamped == '0) ? S_BOOM : S_RUN;
        end
      end
      S_RUN: begin
        if (defuse) begin
          state_d = S_DEFUSED;
        end else if (pause_w) begin
          state_d = S_PAUSED;
        end else if (sec_tick) begin
          digits_d = digits_dec;
          if (digits_dec == '0) begin
            state_d = S_BOOM;
            div_d   = '0;
            phase_d = 1'b0;
          end
        end
      end
      S_PAUSED: begin
        if (defuse)       state_d = S_DEFUSED;
        else if (pause_w) state_d = S_RUN;
      end
      S_DEFUSED: begin
        if (clear) begin
          state_d  = S_IDLE;
          digits_d = '0;
        end
      end
      S_BOOM: begin
        if (half_tick) blink_d = ~blink_q;
        if (clear) begin
          state_d  = S_IDLE;
          digits_d = '0;
          blink_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state_q  <= S_IDLE;
      digits_q <= '0;
      div_q    <= '0;
      phase_q  <= 1'b0;
      blink_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      blink_q  <= blink_d;
    end
  end

  assign state    = state_q;
  assign exploded = (state_q == S_BOOM);

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    countdown_seg_dec u_dec (
      .bcd   (digits_q[g]),
      .boom  (exploded),
      .blank (blink_q),
      .seg   (hex_out[8*g +: 8])
    );
  end
endmodule

// File: tb/tb_countdown_display_ctrl.sv
// Bench for countdown_display_ctrl (DIGITS=4, HALF_PERIOD=2): a directed
// vector table, hand sequences for the multi-cycle corners, then random
// pulses compared against an integer-valued reference model.
module tb_countdown_display_ctrl;
  localparam int HP = 2;

  logic        clk = 1'b0;
  logic        async_nreset = 1'b0;
  logic        start = 1'b0, defuse = 1'b0, clear = 1'b0, pause_i = 1'b0;
  logic [15:0] preset_bcd = '0;
  logic [31:0] hex_out;
  logic [2:0]  state;
  logic        exploded;

  int checks = 0;
  int errors = 0;
  bit model_chk = 1'b0;

  countdown_display_ctrl #(.DIGITS(4), .HALF_PERIOD(HP)) dut (
    .clk          (clk),
    .async_nreset (async_nreset),
    .start        (start),
    .defuse       (defuse),
`ifdef COUNTDOWN_PAUSE_EN
    .pause        (pause_i),
`endif
    .clear        (clear),
    .preset_bcd   (preset_bcd),
    .hex_out      (hex_out),
    .state        (state),
    .exploded     (exploded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // ---------------- reference model: value kept as a plain integer ----------
  typedef struct {
    int st;   // 0 idle, 1 countdown, 2 paused, 3 defused, 4 boom
    int v;    // remaining seconds as a decimal integer
    int rc;   // cycles spent counting since start
    int bc;   // cycles spent in boom
  } model_t;

  model_t m;

  function automatic int clampval(input logic [15:0] pre);
    int v = 0, w = 1;
    for (int i = 0; i < 4; i++) begin
      int n = int'(pre[4*i +: 4]);
      if (n > 9) n = 9;
      v += n * w;
      w *= 10;
    end
    return v;
  endfunction

  function automatic model_t step_model(input model_t c, input logic s, input logic d,
                                        input logic cl, input logic p, input logic [15:0] pre);
    model_t n = c;
    case (c.st)
      0: if (s) begin
        n.v = clampval(pre); n.rc = 0; n.bc = 0;
        n.st = (n.v == 0) ? 4 : 1;
      end
      1: begin
        n.rc = c.rc + 1;
        if (d) n.st = 3;
        else if (p) n.st = 2;
        else if (n.rc % (2 * HP) == 0) begin
          n.v = c.v - 1;
          if (n.v == 0) begin n.st = 4; n.bc = 0; end
        end
      end
      2: if (d) n.st = 3; else if (p) n.st = 1;
      3: if (cl) begin n.st = 0; n.v = 0; end
      default: begin
        n.bc = c.bc + 1;
        if (cl) begin n.st = 0; n.v = 0; end
      end
    endcase
    return n;
  endfunction

  function automatic logic [31:0] model_hex(input model_t c);
    logic [7:0] lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [31:0] h = '0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      if (c.st == 4) h[8*i +: 8] = ((c.bc / HP) % 2 == 0) ? 8'hBF : 8'hFF;
      else           h[8*i +: 8] = lut[(c.v / w) % 10];
      w *= 10;
    end
    return h;
  endfunction

  // Model advances on the same edges as the DUT
  always @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) m <= '{st: 0, v: 0, rc: 0, bc: 0};
    else               m <= step_model(m, start, defuse, clear, pause_i, preset_bcd);
  end

  // ---------------- directed vectors ----------------------------------------
  typedef struct {
    logic        s, d, c;
    logic [15:0] pre;
    int          after;   // edges after the sampling edge before checking
    logic [2:0]  st;
    logic [31:0] hex;
    logic        ex;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{1, 0, 0, 16'h0012,  4, 3'd1, 32'hC0C0F9F9, 1'b0};
    tbl[1]  = '{0, 0, 0, 16'h0000,  3, 3'd1, 32'hC0C0F9C0, 1'b0};
    tbl[2]  = '{0, 0, 0, 16'h0000, 39, 3'd4, 32'hBFBFBFBF, 1'b1};
    tbl[3]  = '{0, 0, 0, 16'h0000,  1, 3'd4, 32'hFFFFFFFF, 1'b1};
    tbl[4]  = '{0, 0, 0, 16'h0000,  1, 3'd4, 32'hBFBFBFBF, 1'b1};
    tbl[5]  = '{0, 0, 1, 16'h0000,  0, 3'd0, 32'hC0C0C0C0, 1'b0};
    tbl[6]  = '{1, 0, 0, 16'h0100,  4, 3'd1, 32'hC0C09090, 1'b0};
    tbl[7]  = '{0, 0, 1, 16'h0000,  0, 3'd1, 32'hC0C09090, 1'b0};
    tbl[8]  = '{0, 1, 0, 16'h0000,  0, 3'd3, 32'hC0C09090, 1'b0};
    tbl[9]  = '{1, 0, 0, 16'h1234,  0, 3'd3, 32'hC0C09090, 1'b0};
    tbl[10] = '{0, 0, 1, 16'h0000,  0, 3'd0, 32'hC0C0C0C0, 1'b0};
    tbl[11] = '{1, 0, 0, 16'h00AF,  0, 3'd1, 32'hC0C09090, 1'b0};
    tbl[12] = '{0, 1, 0, 16'h0000,  0, 3'd3, 32'hC0C09090, 1'b0};
    tbl[13] = '{0, 0, 1, 16'h0000,  0, 3'd0, 32'hC0C0C0C0, 1'b0};
    tbl[14] = '{1, 0, 0, 16'h0000,  0, 3'd4, 32'hBFBFBFBF, 1'b1};
    tbl[15] = '{0, 0, 1, 16'h0000,  0, 3'd0, 32'hC0C0C0C0, 1'b0};
    tbl[16] = '{1, 0, 1, 16'h0005,  0, 3'd1, 32'hC0C0C092, 1'b0};
    tbl[17] = '{0, 1, 0, 16'h0000,  0, 3'd3, 32'hC0C0C092, 1'b0};
    tbl[18] = '{0, 0, 1, 16'h0000,  0, 3'd0, 32'hC0C0C0C0, 1'b0};
    tbl[19] = '{1, 0, 0, 16'h9999,  0, 3'd1, 32'h90909090, 1'b0};

    // reset state
    #12;
    chk("reset_hex", hex_out, 32'hC0C0C0C0);
    chk("reset_state", {29'd0, state}, 32'd0);
    chk("reset_exploded", {31'd0, exploded}, 32'd0);
    @(negedge clk);
    async_nreset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      start = tbl[i].s; defuse = tbl[i].d; clear = tbl[i].c; preset_bcd = tbl[i].pre;
      @(negedge clk);
      start = 1'b0; defuse = 1'b0; clear = 1'b0;
      repeat (tbl[i].after) @(negedge clk);
      chk($sformatf("vec%0d_state", i), {29'd0, state}, {29'd0, tbl[i].st});
      chk($sformatf("vec%0d_hex", i), hex_out, tbl[i].hex);
      chk($sformatf("vec%0d_exploded", i), {31'd0, exploded}, {31'd0, tbl[i].ex});
    end

    // asynchronous reset mid-countdown takes effect without a clock edge
    #2 async_nreset = 1'b0;
    #1;
    chk("async_rst_state", {29'd0, state}, 32'd0);
    chk("async_rst_hex", hex_out, 32'hC0C0C0C0);
    @(negedge clk);
    async_nreset = 1'b1;
    repeat (10) @(negedge clk);
    chk("after_rst_idle", {29'd0, state}, 32'd0);
    chk("after_rst_hex", hex_out, 32'hC0C0C0C0);

    // defuse on the terminal-tick cycle wins over BOOM
    start = 1'b1; preset_bcd = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    defuse = 1'b1;
    @(negedge clk);
    defuse = 1'b0;
    chk("term_defuse_state", {29'd0, state}, 32'd3);
    chk("term_defuse_hex", hex_out, 32'hC0C0C0F9);
    chk("term_defuse_exploded", {31'd0, exploded}, 32'd0);
    repeat (10) @(negedge clk);
    chk("defused_frozen_hex", hex_out, 32'hC0C0C0F9);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("defused_clear_state", {29'd0, state}, 32'd0);
    chk("defused_clear_hex", hex_out, 32'hC0C0C0C0);

`ifdef COUNTDOWN_PAUSE_EN
    // pause one cycle after start, hold 20 cycles, resume; paused cycles do not count
    start = 1'b1; preset_bcd = 16'h0002;
    @(negedge clk);
    start = 1'b0; pause_i = 1'b1;
    @(negedge clk);
    pause_i = 1'b0;
    chk("paused_state", {29'd0, state}, 32'd2);
    repeat (19) @(negedge clk);
    chk("paused_hold_state", {29'd0, state}, 32'd2);
    chk("paused_hold_hex", hex_out, 32'hC0C0C0A4);
    pause_i = 1'b1;
    @(negedge clk);
    pause_i = 1'b0;
    chk("resume_state", {29'd0, state}, 32'd1);
    start = 1'b1; preset_bcd = 16'h0009;   // ignored while running
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("resume_pre_dec_hex", hex_out, 32'hC0C0C0A4);
    @(negedge clk);
    chk("resume_dec_hex", hex_out, 32'hC0C0C0F9);
    chk("resume_dec_state", {29'd0, state}, 32'd1);
`endif

    // random pulses against the reference model
    async_nreset = 1'b0;
    @(negedge clk);
    async_nreset = 1'b1;
    model_chk = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      chk("rand_state", {29'd0, state}, m.st);
      chk("rand_hex", hex_out, model_hex(m));
      chk("rand_exploded", {31'd0, exploded}, {31'd0, m.st == 4});
      start  = ($urandom_range(0, 29) == 0);
      defuse = ($urandom_range(0, 79) == 0);
      clear  = ($urandom_range(0, 14) == 0);
`ifdef COUNTDOWN_PAUSE_EN
      pause_i = ($urandom_range(0, 39) == 0);
`endif
      preset_bcd = {4'd0,
                    ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 1)) : 4'd0,
                    4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15))};
      @(negedge clk);
    end
    start = 1'b0; defuse = 1'b0; clear = 1'b0; pause_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
